// File: rtl/vga_pkg.sv
// vga_pkg: shared 1280x720 timing constants, bus widths and the timing bundle type
// used by every stage of the pixel pipeline.
package vga_pkg;

    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;
    localparam int H_TOTAL  = 1650;
    localparam int V_TOTAL  = 750;

    localparam int COUNT_W  = 11;
    localparam int RGB_W    = 12;
    localparam int POS_W    = 12;

    localparam logic [RGB_W-1:0] BLACK = 12'h000;

    // Everything the timing generator produces, travelling together down the pipe.
    typedef struct packed {
        logic [COUNT_W-1:0] hcount;
        logic               hsync;
        logic               hblnk;
        logic [COUNT_W-1:0] vcount;
        logic               vsync;
        logic               vblnk;
    } timing_t;

    localparam int TIMING_W = $bits(timing_t);

endpackage

// File: rtl/vga_delay.sv
// vga_delay: N-stage, W-bit register chain with asynchronous active-low reset.
module vga_delay #(
    parameter int W = 1,
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe [N];

    // Shift din one stage per clock; every stage clears on reset.
    // NOTE: the chain is only a few flops, not a RAM, so resetting each stage costs nothing and keeps outputs defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[N-1];

endmodule

// File: rtl/draw_rect.sv
// draw_rect: overlays a solid rectangle on the incoming 1280x720 pixel stream.
// Two-cycle pipeline; the rectangle position is captured once per frame on the
// rising edge of vblnk so a frame is never drawn half old / half new.
// Optional: define DRAW_RECT_BORDER_EN to outline the rectangle in BORDER_RGB.
module draw_rect
    import vga_pkg::*;
#(
    parameter int                RECT_W     = 64,
    parameter int                RECT_H     = 48,
    parameter logic [RGB_W-1:0]  RECT_RGB   = 12'hF80,
    parameter logic [RGB_W-1:0]  BORDER_RGB = 12'hFFF
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic [COUNT_W-1:0] hcount_in,
    input  logic               hsync_in,
    input  logic               hblnk_in,
    input  logic [COUNT_W-1:0] vcount_in,
    input  logic               vsync_in,
    input  logic               vblnk_in,
    input  logic [RGB_W-1:0]   rgb_in,
    input  logic [POS_W-1:0]   xpos,
    input  logic [POS_W-1:0]   ypos,
    output logic [COUNT_W-1:0] hcount_out,
    output logic               hsync_out,
    output logic               hblnk_out,
    output logic [COUNT_W-1:0] vcount_out,
    output logic               vsync_out,
    output logic               vblnk_out,
    output logic [RGB_W-1:0]   rgb_out,
    output logic               pos_latched
);

    // One extra bit over POS_W so x_q + RECT_W can never wrap back into range.
    localparam int EXT_W = POS_W + 1;

    logic             vblnk_prev;
    logic             frame_edge;
    logic [POS_W-1:0] x_q;
    logic [POS_W-1:0] y_q;

    assign frame_edge = vblnk_in & ~vblnk_prev;

    // Capture the requested position at the start of vertical blanking only.
    // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_prev  <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            pos_latched <= 1'b0;
        end else begin
            vblnk_prev  <= vblnk_in;
            pos_latched <= frame_edge;
            if (frame_edge) begin
                x_q <= xpos;
                y_q <= ypos;
            end
        end
    end

    logic [EXT_W-1:0] h_ext, v_ext, x_lo, x_hi, y_lo, y_hi;
    logic             hit;

    assign h_ext = {2'b00, hcount_in};
    assign v_ext = {2'b00, vcount_in};
    assign x_lo  = {1'b0, x_q};
    assign y_lo  = {1'b0, y_q};
    assign x_hi  = x_lo + EXT_W'(RECT_W);
    assign y_hi  = y_lo + EXT_W'(RECT_H);

    assign hit = (h_ext >= x_lo) && (h_ext < x_hi) &&
                 (v_ext >= y_lo) && (v_ext < y_hi);

`ifdef DRAW_RECT_BORDER_EN
    logic on_edge;
    assign on_edge = (h_ext == x_lo) || (h_ext == x_hi - EXT_W'(1)) ||
                     (v_ext == y_lo) || (v_ext == y_hi - EXT_W'(1));
`else
    logic unused_border;
    assign unused_border = ^BORDER_RGB;
`endif

    // Timing signals ride a plain two-stage delay, matching the colour path.
    timing_t tim_in, tim_out;

    assign tim_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                      vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};

    vga_delay #(.W(TIMING_W), .N(2)) u_timing_delay (
        .clk   (pclk),
        .rst_n (rst_n),
        .din   (tim_in),
        .dout  (tim_out)
    );

    assign hcount_out = tim_out.hcount;
    assign hsync_out  = tim_out.hsync;
    assign hblnk_out  = tim_out.hblnk;
    assign vcount_out = tim_out.vcount;
    assign vsync_out  = tim_out.vsync;
    assign vblnk_out  = tim_out.vblnk;

    logic [RGB_W-1:0] rgb_s1;
    logic             hit_s1;
    logic             blank_s1;
`ifdef DRAW_RECT_BORDER_EN
    logic             edge_s1;
`endif

    // Stage 1: register background colour, blanking and the hit decision.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_s1   <= '0;
            hit_s1   <= 1'b0;
            blank_s1 <= 1'b0;
`ifdef DRAW_RECT_BORDER_EN
            edge_s1  <= 1'b0;
`endif
        end else begin
            rgb_s1   <= rgb_in;
            hit_s1   <= hit;
            blank_s1 <= hblnk_in | vblnk_in;
`ifdef DRAW_RECT_BORDER_EN
            edge_s1  <= hit & on_edge;
`endif
        end
    end

    // Stage 2: composite; blanking wins, then outline, then fill, then background.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out <= '0;
        end else if (blank_s1) begin
            rgb_out <= BLACK;
`ifdef DRAW_RECT_BORDER_EN
        end else if (edge_s1) begin
            rgb_out <= BORDER_RGB;
`endif
        end else if (hit_s1) begin
            rgb_out <= RECT_RGB;
        end else begin
            rgb_out <= rgb_s1;
        end
    end

endmodule

// File: tb/tb_draw_rect.sv
// tb_draw_rect: directed self-checking bench for draw_rect.
// Drives pixels straight to the regions of interest instead of whole frames.
// Honours DRAW_RECT_BORDER_EN the same way the design does.
module tb_draw_rect;
    import vga_pkg::*;

    localparam int          RW       = 64;
    localparam int          RH       = 48;
    localparam logic [11:0] RECT_C   = 12'hF80;
    localparam logic [11:0] BORDER_C = 12'hFFF;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0, xpos = '0, ypos = '0;

    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out, pos_latched;
    logic [11:0] rgb_out;
    logic [25:0] tim_out;

    int compared   = 0;
    int mismatched = 0;
    int mx = 0, my = 0;

    logic [25:0] nxt_tim = '0, due_tim = '0;
    logic [11:0] nxt_rgb = '0, due_rgb = '0;

    always #5 pclk = ~pclk;

    draw_rect dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .hcount_in   (hcount_in),
        .hsync_in    (hsync_in),
        .hblnk_in    (hblnk_in),
        .vcount_in   (vcount_in),
        .vsync_in    (vsync_in),
        .vblnk_in    (vblnk_in),
        .rgb_in      (rgb_in),
        .xpos        (xpos),
        .ypos        (ypos),
        .hcount_out  (hcount_out),
        .hsync_out   (hsync_out),
        .hblnk_out   (hblnk_out),
        .vcount_out  (vcount_out),
        .vsync_out   (vsync_out),
        .vblnk_out   (vblnk_out),
        .rgb_out     (rgb_out),
        .pos_latched (pos_latched)
    );

    assign tim_out = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out};

    // Expected colour of one pixel given the position the bench believes is latched.
    function automatic logic [11:0] model_rgb(input int h, input int v, input logic [11:0] bg);
        if (h >= 1280 || v >= 720) return 12'h000;
        if (h >= mx && h < mx + RW && v >= my && v < my + RH) begin
`ifdef DRAW_RECT_BORDER_EN
            if (h == mx || h == mx + RW - 1 || v == my || v == my + RH - 1) return BORDER_C;
`endif
            return RECT_C;
        end
        return bg;
    endfunction

    // Present one pixel for one clock. Afterwards due_* holds what the outputs
    // must show now: the pixel presented on the previous call.
    task automatic drive(input int h, input int v, input logic [11:0] bg);
        logic        hs, hb, vs, vb;
        logic [25:0] t;
        logic [11:0] e;
        hb = (h >= 1280);
        vb = (v >= 720);
        hs = (h >= 1390 && h < 1430);
        vs = (v >= 725 && v < 730);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = hs;
        hblnk_in  = hb;
        vsync_in  = vs;
        vblnk_in  = vb;
        rgb_in    = bg;
        t = {11'(h), hs, hb, 11'(v), vs, vb};
        e = model_rgb(h, v, bg);
        if (!rst_n) begin
            t = '0;
            e = '0;
        end
        @(posedge pclk);
        #1;
        due_tim = nxt_tim;
        due_rgb = nxt_rgb;
        nxt_tim = t;
        nxt_rgb = e;
    endtask

    // Produce a vblnk rising edge with the given request, then leave blanking.
    task automatic latch_pos(input int x, input int y);
        xpos = 12'(x);
        ypos = 12'(y);
        drive(1279, 719, 12'h000);
        drive(0, 720, 12'h000);
        mx = x;
        my = y;
        drive(1, 720, 12'h000);
    endtask

    task automatic test_reset();
        int rect_px;
        // Activity while held in reset: everything must stay zero.
        for (int i = 0; i < 10; i++) begin
            xpos = 12'(7 * i + 3);
            ypos = 12'(5 * i + 1);
            drive(100 * i + 1, (i == 4) ? 720 : 3 + i, 12'hABC);
            compared++;
            if ({tim_out, rgb_out, pos_latched} !== '0) begin
                mismatched++;
                $display("FAIL reset_hold cycle %0d: got tim=%h rgb=%h pl=%b, want all zero",
                         i, tim_out, rgb_out, pos_latched);
            end
        end
        mx = 0;
        my = 0;
        xpos = 12'd300;
        ypos = 12'd300;
        #2 rst_n = 1'b1;
        // Release mid-line: outputs track the input two cycles later.
        for (int h = 600; h < 606; h++) begin
            drive(h, 5, 12'h0A5);
            compared++;
            if (rgb_out !== due_rgb || tim_out !== due_tim) begin
                mismatched++;
                $display("FAIL reset_release h=%0d: got rgb=%h tim=%h, want rgb=%h tim=%h",
                         h, rgb_out, tim_out, due_rgb, due_tim);
            end
        end
        // No vblnk edge yet, so the rectangle sits at (0,0).
        rect_px = 0;
        for (int h = 0; h <= 71; h++) begin
            drive(h, 6, 12'h0A5);
            compared++;
            if (rgb_out !== due_rgb || tim_out !== due_tim) begin
                mismatched++;
                $display("FAIL reset_origin h=%0d: got rgb=%h tim=%h, want rgb=%h tim=%h",
                         h, rgb_out, tim_out, due_rgb, due_tim);
            end
            if (rgb_out == RECT_C || rgb_out == BORDER_C) rect_px++;
        end
        drive(1300, 6, 12'h0A5);
        if (rgb_out == RECT_C || rgb_out == BORDER_C) rect_px++;
        compared++;
        if (rect_px !== 64) begin
            mismatched++;
            $display("FAIL reset_origin_count: got %0d rectangle pixels, want 64", rect_px);
        end
        // Asynchronous assertion: outputs clear without any clock edge.
        drive(400, 8, 12'h0A5);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({tim_out, rgb_out, pos_latched} !== '0) begin
            mismatched++;
            $display("FAIL reset_async: got tim=%h rgb=%h pl=%b, want all zero",
                     tim_out, rgb_out, pos_latched);
        end
        drive(401, 8, 12'h0A5);
        #2 rst_n = 1'b1;
        for (int h = 402; h < 406; h++) begin
            drive(h, 8, 12'h0A5);
            compared++;
            if (rgb_out !== due_rgb || tim_out !== due_tim) begin
                mismatched++;
                $display("FAIL reset_async_refill h=%0d: got rgb=%h tim=%h, want rgb=%h tim=%h",
                         h, rgb_out, tim_out, due_rgb, due_tim);
            end
        end
    endtask

    task automatic test_basic_draw();
        int rect_px;
        latch_pos(100, 200);
        rect_px = 0;
        for (int v = 195; v <= 252; v++) begin
            for (int h = 90; h <= 175; h++) begin
                drive(h, v, 12'h00F);
                compared++;
                if (rgb_out !== due_rgb || tim_out !== due_tim) begin
                    mismatched++;
                    $display("FAIL basic_draw h=%0d v=%0d: got rgb=%h tim=%h, want rgb=%h tim=%h",
                             h, v, rgb_out, tim_out, due_rgb, due_tim);
                end
                if (rgb_out == RECT_C || rgb_out == BORDER_C) rect_px++;
            end
        end
        drive(1300, 252, 12'h00F);
        if (rgb_out == RECT_C || rgb_out == BORDER_C) rect_px++;
        compared++;
        if (rect_px !== 3072) begin
            mismatched++;
            $display("FAIL basic_draw_count: got %0d rectangle pixels, want 3072", rect_px);
        end
    endtask

    task automatic test_alignment();
        int h, v, blank_bad;
        blank_bad = 0;
        // Walk 1800 raster pixels through vsync, then 2000 across the frame wrap,
        // with a white background so any leak through blanking shows up.
        for (int seg = 0; seg < 2; seg++) begin
            h = (seg == 0) ? 1300 : 1600;
            v = (seg == 0) ? 724 : 748;
            for (int n = 0; n < ((seg == 0) ? 1800 : 2000); n++) begin
                drive(h, v, 12'hFFF);
                compared++;
                if (rgb_out !== due_rgb || tim_out !== due_tim) begin
                    mismatched++;
                    $display("FAIL align h=%0d v=%0d: got rgb=%h tim=%h, want rgb=%h tim=%h",
                             h, v, rgb_out, tim_out, due_rgb, due_tim);
                end
                if ((hblnk_out || vblnk_out) && rgb_out !== 12'h000) blank_bad++;
                h++;
                if (h == 1650) begin
                    h = 0;
                    v = (v == 749) ? 0 : v + 1;
                end
            end
        end
        compared++;
        if (blank_bad !== 0) begin
            mismatched++;
            $display("FAIL align_blank_black: got %0d non-black blank pixels, want 0", blank_bad);
        end
    endtask

    task automatic test_latch_timing();
        int pulses;
        latch_pos(100, 340);
        for (int ln = 360; ln <= 361; ln++) begin
            for (int k = 0; k < 2; k++) begin
                for (int h = (k == 0 ? 95 : 495); h <= (k == 0 ? 105 : 505); h++) begin
                    drive(h, ln, 12'h050);
                    if (ln == 360 && h == 95) xpos = 12'd500;
                    compared++;
                    if (rgb_out !== due_rgb || tim_out !== due_tim || pos_latched !== 1'b0) begin
                        mismatched++;
                        $display("FAIL latch_old h=%0d v=%0d: got rgb=%h pl=%b, want rgb=%h pl=0",
                                 h, ln, rgb_out, pos_latched, due_rgb);
                    end
                end
            end
        end
        drive(1279, 719, 12'h050);
        compared++;
        if (pos_latched !== 1'b0) begin
            mismatched++;
            $display("FAIL latch_pulse_early: got pos_latched=%b, want 0", pos_latched);
        end
        drive(0, 720, 12'h050);
        mx = 500;
        compared++;
        if (pos_latched !== 1'b1) begin
            mismatched++;
            $display("FAIL latch_pulse: got pos_latched=%b, want 1", pos_latched);
        end
        pulses = 0;
        for (int h = 1; h <= 30; h++) begin
            drive(h, 720, 12'h050);
            if (pos_latched) pulses++;
        end
        for (int ln = 360; ln <= 361; ln++) begin
            for (int k = 0; k < 2; k++) begin
                for (int h = (k == 0 ? 95 : 495); h <= (k == 0 ? 105 : 505); h++) begin
                    drive(h, ln, 12'h050);
                    if (pos_latched) pulses++;
                    compared++;
                    if (rgb_out !== due_rgb || tim_out !== due_tim) begin
                        mismatched++;
                        $display("FAIL latch_new h=%0d v=%0d: got rgb=%h, want rgb=%h",
                                 h, ln, rgb_out, due_rgb);
                    end
                end
            end
        end
        compared++;
        if (pulses !== 0) begin
            mismatched++;
            $display("FAIL latch_single_pulse: got %0d extra pulses, want 0", pulses);
        end
    endtask

    task automatic test_clipping();
        int rect_px;
        latch_pos(1250, 700);
        rect_px = 0;
        for (int v = 695; v <= 722; v++) begin
            for (int h = 1240; h <= 1300; h++) begin
                drive(h, v, 12'h00F);
                compared++;
                if (rgb_out !== due_rgb || tim_out !== due_tim) begin
                    mismatched++;
                    $display("FAIL clip h=%0d v=%0d: got rgb=%h tim=%h, want rgb=%h tim=%h",
                             h, v, rgb_out, tim_out, due_rgb, due_tim);
                end
                if (rgb_out == RECT_C || rgb_out == BORDER_C) rect_px++;
            end
        end
        drive(1300, 722, 12'h00F);
        if (rgb_out == RECT_C || rgb_out == BORDER_C) rect_px++;
        compared++;
        if (rect_px !== 600) begin
            mismatched++;
            $display("FAIL clip_count: got %0d rectangle pixels, want 600", rect_px);
        end
        latch_pos(4000, 0);
        rect_px = 0;
        for (int v = 0; v <= 1; v++) begin
            for (int h = 0; h < 1650; h++) begin
                drive(h, v, 12'h00F);
                compared++;
                if (rgb_out !== due_rgb || tim_out !== due_tim) begin
                    mismatched++;
                    $display("FAIL offscreen h=%0d v=%0d: got rgb=%h, want rgb=%h",
                             h, v, rgb_out, due_rgb);
                end
                if (rgb_out == RECT_C || rgb_out == BORDER_C) rect_px++;
            end
        end
        compared++;
        if (rect_px !== 0) begin
            mismatched++;
            $display("FAIL offscreen_count: got %0d rectangle pixels, want 0", rect_px);
        end
    endtask

    task automatic test_border();
        int perim, inner, want_perim, want_inner;
`ifdef DRAW_RECT_BORDER_EN
        want_perim = 220;
        want_inner = 2852;
`else
        want_perim = 0;
        want_inner = 3072;
`endif
        latch_pos(10, 10);
        perim = 0;
        inner = 0;
        for (int v = 5; v <= 64; v++) begin
            for (int h = 5; h <= 80; h++) begin
                drive(h, v, 12'h00F);
                compared++;
                if (rgb_out !== due_rgb || tim_out !== due_tim) begin
                    mismatched++;
                    $display("FAIL border h=%0d v=%0d: got rgb=%h, want rgb=%h",
                             h, v, rgb_out, due_rgb);
                end
                if (rgb_out == BORDER_C) perim++;
                if (rgb_out == RECT_C) inner++;
            end
        end
        drive(1300, 64, 12'h00F);
        if (rgb_out == BORDER_C) perim++;
        if (rgb_out == RECT_C) inner++;
        compared++;
        if (perim !== want_perim || inner !== want_inner) begin
            mismatched++;
            $display("FAIL border_count: got perimeter=%0d interior=%0d, want perimeter=%0d interior=%0d",
                     perim, inner, want_perim, want_inner);
        end
    endtask

    initial begin
        test_reset();
        test_basic_draw();
        test_alignment();
        test_latch_timing();
        test_clipping();
        test_border();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
